// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache line refill engine.
package cache_pkg;

  localparam int ADDRESS_WORD_SIZE = 32;  // byte-address width
  localparam int TAG_SIZE          = 19;  // tag = addr[31:13]
  localparam int BLOCK_SIZE        = 16;  // 32-bit words per line
  localparam int WORD_SIZE         = 4;   // bytes per word

  localparam int WORD_BITS      = WORD_SIZE * 8;
  localparam int LINE_BITS      = BLOCK_SIZE * WORD_SIZE * 8;
  localparam int INDEX_LSB      = 6;
  localparam int TAG_LSB        = ADDRESS_WORD_SIZE - TAG_SIZE;
  localparam int INDEX_BITS     = TAG_LSB - INDEX_LSB;
  localparam int LINE_ADDR_BITS = ADDRESS_WORD_SIZE - INDEX_LSB;
  localparam int CNT_BITS       = $clog2(BLOCK_SIZE);
  localparam int BYTE_OFF_BITS  = $clog2(WORD_SIZE);

  localparam logic [2:0] IDLE_ENC     = 3'd0;
  localparam logic [2:0] WB_REQ_ENC   = 3'd1;
  localparam logic [2:0] FILL_REQ_ENC = 3'd2;
  localparam logic [2:0] FILL_RSP_ENC = 3'd3;
  localparam logic [2:0] DONE_ENC     = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = IDLE_ENC,
    WB_REQ   = WB_REQ_ENC,
    FILL_REQ = FILL_REQ_ENC,
    FILL_RSP = FILL_RSP_ENC,
    DONE     = DONE_ENC
  } state_t;

endpackage

// File: rtl/cache_line_refill.sv
// Miss engine: optional 16-word victim writeback, then 16 single-word reads
// (one outstanding) assembled into a 512-bit line, reported by a done pulse.
module cache_line_refill
  import cache_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         start,
  input  logic [ADDRESS_WORD_SIZE-1:0] miss_address,
  input  logic                         victim_dirty,
  input  logic [TAG_SIZE-1:0]          victim_tag,
  input  logic [LINE_BITS-1:0]         victim_data,
  output logic                         busy,
  output logic                         done,
  output logic [LINE_BITS-1:0]         fill_data,
  output logic [TAG_SIZE-1:0]          fill_tag,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic                         mem_req_write,
  output logic [ADDRESS_WORD_SIZE-1:0] mem_req_addr,
  output logic [WORD_BITS-1:0]         mem_req_wdata,
  input  logic                         mem_rsp_valid,
  input  logic [WORD_BITS-1:0]         mem_rsp_data
);

  state_t                    state_q, state_d;
  logic [CNT_BITS-1:0]       cnt_q;
  logic [LINE_ADDR_BITS-1:0] line_addr_q;    // miss_address[31:6]: tag + index
  logic [TAG_SIZE-1:0]       victim_tag_q;
  logic [LINE_BITS-1:0]      victim_data_q;
  logic [LINE_BITS-1:0]      fill_data_q;
  logic                      accept;

  // The byte offset inside the line never reaches the memory side.
  logic unused_offset_bits;
  assign unused_offset_bits = ^miss_address[INDEX_LSB-1:0];

  // A new miss is taken only from IDLE; start in any other state is dropped.
  assign accept = (state_q == IDLE) && start;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = victim_dirty ? WB_REQ : FILL_REQ;
      WB_REQ:   if (mem_req_ready && (cnt_q == '1)) state_d = FILL_REQ;
      FILL_REQ: if (mem_req_ready) state_d = FILL_RSP;
      FILL_RSP: if (mem_rsp_valid) state_d = (cnt_q == '1) ? DONE : FILL_REQ;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Word counter, latched miss context and the assembled fill line.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q        <= '0;
      line_addr_q  <= '0;
      victim_tag_q <= '0;
      fill_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q        <= '0;
            line_addr_q  <= miss_address[ADDRESS_WORD_SIZE-1:INDEX_LSB];
            victim_tag_q <= victim_tag;
          end
        end
        WB_REQ: begin
          // Wraps 15 -> 0 on the last write, ready for the fill phase.
          if (mem_req_ready) cnt_q <= cnt_q + 1'b1;
        end
        FILL_RSP: begin
          if (mem_rsp_valid) begin
            fill_data_q[int'(cnt_q)*WORD_BITS +: WORD_BITS] <= mem_rsp_data;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Victim line copy, loaded on every accepted miss.
  // NOTE: this wide storage is deliberately left out of reset: it is always
  // written by an accepted start before WB_REQ ever reads it.
  always_ff @(posedge clk) begin
    if (accept) victim_data_q <= victim_data;
  end

  // Request channel is a pure decode of registered state, so it never
  // depends combinationally on mem_req_ready and holds steady while stalled.
  always_comb begin
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state_q)
      WB_REQ: begin
        mem_req_addr  = {victim_tag_q, line_addr_q[INDEX_BITS-1:0], cnt_q,
                         {BYTE_OFF_BITS{1'b0}}};
        mem_req_wdata = victim_data_q[int'(cnt_q)*WORD_BITS +: WORD_BITS];
      end
      FILL_REQ: mem_req_addr = {line_addr_q, cnt_q, {BYTE_OFF_BITS{1'b0}}};
      default: ;
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign mem_req_valid = (state_q == WB_REQ) || (state_q == FILL_REQ);
  assign mem_req_write = (state_q == WB_REQ);
  assign fill_data     = fill_data_q;
  assign fill_tag      = line_addr_q[LINE_ADDR_BITS-1 -: TAG_SIZE];

endmodule

// File: tb/tb_cache_line_refill.sv
// Self-checking bench for cache_line_refill: directed scenario table plus
// randomized misses against a transaction-level memory model.
module tb_cache_line_refill;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         start;
  logic [31:0]  miss_address;
  logic         victim_dirty;
  logic [18:0]  victim_tag;
  logic [511:0] victim_data;
  logic         busy;
  logic         done;
  logic [511:0] fill_data;
  logic [18:0]  fill_tag;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [31:0]  mem_req_wdata;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rsp_data;

  always #5 clk = ~clk;

  cache_line_refill dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .start         (start),
    .miss_address  (miss_address),
    .victim_dirty  (victim_dirty),
    .victim_tag    (victim_tag),
    .victim_data   (victim_data),
    .busy          (busy),
    .done          (done),
    .fill_data     (fill_data),
    .fill_tag      (fill_tag),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_write (mem_req_write),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the line should hold after the last completed miss.
  logic [31:0]  rsp_words [16];
  logic [511:0] exp_fill;
  logic [18:0]  exp_tag;

  typedef struct {
    logic [31:0] addr;
    logic        dirty;
    logic [18:0] vtag;
    logic [31:0] vbase;      // victim word k = vbase + k
    logic [31:0] rbase;      // memory read word k = rbase + k
    int          stall;      // ready held low this many cycles per request
    int          delay;      // extra cycles before each read response
    bit          stray;      // pulse mem_rsp_valid while a read request waits
    int          glitch;     // cycle index for a stray start (0 = none)
    bit          start_on_done;
    int          abort;      // cycle index to pull reset (0 = none)
    int          exp_cycles; // cycle of the done pulse after the start edge
    logic [18:0] exp_tag;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [511:0] got,
                       input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {busy, done, mem_req_valid, mem_req_write, mem_req_addr,
                 mem_req_wdata, fill_tag}, '0);
    check({name, "_fill"}, fill_data, '0);
  endtask

  // Drive one miss and act as lower memory until done; then compare the
  // observed request stream and fill result against the model.
  task automatic run_miss(input logic [31:0] addr, input logic dirty,
                          input logic [18:0] vtag, input logic [511:0] vdata,
                          input int stall, input int delay, input bit stray,
                          input int glitch, input bit start_on_done,
                          input int abort, input int exp_cycles,
                          input logic [18:0] tag_exp);
    logic [31:0] q_addr [$];
    logic        q_wr   [$];
    logic [31:0] q_data [$];
    logic [65:0] snap;
    bit          in_req     = 0;
    bit          pending    = 0;
    int          stall_left = 0;
    int          wait_left  = 0;
    int          rsp_idx    = 0;
    int          busy_low   = 0;
    int          done_cycle = -1;
    int          idx;
    logic [31:0] exp_a;

    miss_address = addr;
    victim_dirty = dirty;
    victim_tag   = vtag;
    victim_data  = vdata;
    start        = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 2000; c++) begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      if (c == glitch) begin
        start        = 1'b1;
        miss_address = 32'h1234_5680;
        victim_dirty = ~dirty;
        victim_tag   = ~vtag;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cycle = c;
        break;
      end
      if (!busy) busy_low++;
      if (in_req) begin
        check("req_stable", {mem_req_valid, mem_req_write, mem_req_addr,
                             mem_req_wdata}, snap);
      end else if (mem_req_valid) begin
        in_req     = 1;
        stall_left = stall;
        snap       = {1'b1, mem_req_write, mem_req_addr, mem_req_wdata};
      end
      if (in_req) begin
        if (stray && !mem_req_write) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = 32'hDEAD_BEEF;
        end
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          mem_req_ready = 1'b1;
          in_req        = 0;
          q_addr.push_back(mem_req_addr);
          q_wr.push_back(mem_req_write);
          q_data.push_back(mem_req_wdata);
          if (!mem_req_write) begin
            pending   = 1;
            wait_left = delay;
          end
        end
      end else if (pending) begin
        if (wait_left > 0) begin
          wait_left--;
        end else begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = (rsp_idx < 16) ? rsp_words[rsp_idx] : 32'h0BAD_0BAD;
          rsp_idx++;
          pending = 0;
        end
      end
      if (c == abort) begin
        exp_a = (32'(vtag) << 13) | (addr & 32'h0000_1FC0) | 32'd28;
        check("abort_word7_addr", mem_req_addr, exp_a);
        rst_b = 1'b0;
        #1;
        check_reset_outputs("abort_reset");
        exp_fill = '0;
        exp_tag  = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end

    check("done_cycle", done_cycle, exp_cycles);
    check("busy_while_active", busy_low, 0);
    check("req_count", q_addr.size(), dirty ? 32 : 16);

    idx = 0;
    if (dirty) begin
      for (int k = 0; k < 16; k++) begin
        if (idx < q_addr.size()) begin
          exp_a = (32'(vtag) << 13) | (addr & 32'h0000_1FC0) | 32'(4 * k);
          check("wb_addr", q_addr[idx], exp_a);
          check("wb_write", q_wr[idx], 1'b1);
          check("wb_data", q_data[idx], vdata[k*32 +: 32]);
        end
        idx++;
      end
    end
    for (int k = 0; k < 16; k++) begin
      if (idx < q_addr.size()) begin
        exp_a = (addr & 32'hFFFF_FFC0) + 32'(4 * k);
        check("rd_addr", q_addr[idx], exp_a);
        check("rd_write", q_wr[idx], 1'b0);
      end
      idx++;
    end

    for (int k = 0; k < 16; k++) exp_fill[k*32 +: 32] = rsp_words[k];
    exp_tag = tag_exp;
    check("fill_data", fill_data, exp_fill);
    check("fill_tag", fill_tag, exp_tag);

    // One cycle after done the engine is idle; a start held in the DONE
    // cycle must not have launched a new miss.
    start        = start_on_done;
    miss_address = 32'hCAFE_0000;
    victim_dirty = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
    check("fill_tag_hold", fill_tag, exp_tag);
  endtask

  initial begin
    logic [511:0] vdata;
    logic [31:0]  addr;
    logic         dirty;
    int           stall, delay;

    rst_b         = 1'b0;
    start         = 1'b0;
    miss_address  = '0;
    victim_dirty  = 1'b0;
    victim_tag    = '0;
    victim_data   = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    exp_fill      = '0;
    exp_tag       = '0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    //          addr          dirty vtag      vbase         rbase          stall dly stray glitch sod abort cycles tag
    vecs[0] = '{32'h0000_2A40, 1'b0, 19'h0,     32'h0,       32'hA5A5_0000, 0,    0,  0,    0,     0,  0,    33,    19'h00001};
    vecs[1] = '{32'h0000_2A40, 1'b1, 19'h7FFFF, 32'h0,       32'h1111_0000, 0,    0,  0,    0,     0,  0,    49,    19'h00001};
    vecs[2] = '{32'h0000_2A40, 1'b0, 19'h0,     32'h0,       32'hA5A5_0000, 3,    0,  0,    0,     0,  0,    81,    19'h00001};
    vecs[3] = '{32'h0000_2A40, 1'b0, 19'h0,     32'h0,       32'h5EED_0000, 0,    0,  0,    10,    0,  0,    33,    19'h00001};
    vecs[4] = '{32'h8000_1000, 1'b0, 19'h0,     32'h0,       32'h7700_0000, 0,    0,  0,    0,     1,  0,    33,    19'h40000};
    vecs[5] = '{32'hFFFF_FFC0, 1'b1, 19'h0ABCD, 32'h100,     32'h2222_0000, 3,    0,  0,    0,     0,  0,    145,   19'h7FFFF};
    vecs[6] = '{32'h0000_0000, 1'b0, 19'h0,     32'h0,       32'h3333_0000, 1,    2,  1,    0,     0,  0,    81,    19'h00000};
    vecs[7] = '{32'h0000_2A40, 1'b1, 19'h7FFFF, 32'h0,       32'h4444_0000, 0,    0,  0,    0,     0,  8,    0,     19'h00001};
    vecs[8] = '{32'h0000_2A40, 1'b0, 19'h0,     32'h0,       32'hA5A5_0000, 0,    0,  0,    0,     0,  0,    33,    19'h00001};

    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < 16; k++) begin
        vdata[k*32 +: 32] = vecs[v].vbase + 32'(k);
        rsp_words[k]      = vecs[v].rbase + 32'(k);
      end
      run_miss(vecs[v].addr, vecs[v].dirty, vecs[v].vtag, vdata,
               vecs[v].stall, vecs[v].delay, vecs[v].stray, vecs[v].glitch,
               vecs[v].start_on_done, vecs[v].abort, vecs[v].exp_cycles,
               vecs[v].exp_tag);
    end
    check("last_word", fill_data[511:480], 32'hA5A5_000F);

    // Stray read responses while idle must leave the line untouched.
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = $urandom;
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;
    check("idle_rsp_ignored", fill_data, exp_fill);
    check("idle_rsp_busy", busy, 1'b0);

    // Randomized misses: latency follows from per-request stall and
    // per-response delay; the stream and line come from the model above.
    for (int t = 0; t < 20; t++) begin
      addr  = $urandom;
      dirty = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 2);
      delay = $urandom_range(0, 2);
      for (int k = 0; k < 16; k++) begin
        vdata[k*32 +: 32] = $urandom;
        rsp_words[k]      = $urandom;
      end
      run_miss(addr, dirty, 19'($urandom), vdata, stall, delay,
               1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 0,
               (dirty ? 32 : 16) * (1 + stall) + 16 * (1 + delay) + 1,
               addr[31:13]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
